audio_frame_feeder: RTL
=======================

AUDIO_FRAME_FEEDER -- requirements
Module: audio_frame_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in stereo pairs (power of two, >= 4).
REQ-002 SHALL have parameter PRIME_LVL, default DEPTH/2, fill level required before playback starts.
REQ-003 SHALL have port Clk  in  1  system clock; the only clock.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port AUDIO_EN  in  1  feeder enable, synchronous to Clk.
REQ-006 SHALL have port LRCLK  in  1  I2S word clock, asynchronous to Clk.
REQ-007 SHALL have port s_valid  in  1  upstream sample pair valid.
REQ-008 SHALL have port s_ready  out  1  feeder can accept a pair.
REQ-009 SHALL have port s_left  in  16  signed left sample.
REQ-010 SHALL have port s_right  in  16  signed right sample.
REQ-011 SHALL have port AUDIO_Reg  out  64  frame presented to the I2S serializer.
REQ-012 SHALL have port frame_strobe  out  1  one-cycle pulse when AUDIO_Reg is loaded.
REQ-013 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current pair count.
REQ-014 SHALL have port underrun_cnt  out  16  saturating underrun counter.
REQ-015 SHALL have port volume  in  4  attenuation shift; present only when AUDIO_VOLUME_EN is defined.

Function
REQ-016 SHALL pass LRCLK through a 2-flop synchronizer, then register it once more for edge detection.
REQ-017 SHALL assert an internal tick for exactly one cycle on each falling edge of the synchronized LRCLK.
REQ-018 SHALL load AUDIO_Reg on the third rising Clk edge after LRCLK falls, counting the sampling edge.
REQ-019 SHALL pack AUDIO_Reg as follows: [63:48]=left, [47:32]=0, [31:16]=right, [15:0]=0 (MSB-first 32-bit slots).
REQ-020 SHALL push a pair when s_valid && s_ready.
REQ-021 SHALL drive s_ready = AUDIO_EN && (fifo_level < DEPTH).
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL accept a push and a pop in the same cycle and leave fifo_level unchanged.
REQ-024 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-025 SHALL go to IDLE from any state when AUDIO_EN=0, flushing the FIFO, zeroing AUDIO_Reg, ignoring ticks and holding underrun_cnt.
REQ-026 SHALL go IDLE->PRIME on the cycle in which AUDIO_EN=1.
REQ-027 SHALL, in PRIME, load zeros into AUDIO_Reg on each tick without popping or counting.
REQ-028 SHALL go PRIME->RUN when fifo_level >= PRIME_LVL.
REQ-029 SHALL, in RUN, pop one pair into AUDIO_Reg on each tick when fifo_level > 0.
REQ-030 SHALL, on a RUN tick with an empty FIFO, load AUDIO_Reg=0, increment underrun_cnt (saturating at 0xFFFF) and go to PRIME.
REQ-031 SHALL NOT bypass a push arriving in the same cycle as an underrun tick; the push is stored and the underrun still counts.
REQ-032 SHALL pulse frame_strobe on every AUDIO_Reg load in PRIME and RUN, and never in IDLE.

Reset
REQ-033 SHALL, while RESET_N=0, immediately force state=IDLE, AUDIO_Reg=0, frame_strobe=0, fifo_level=0, underrun_cnt=0, pointers=0 and synchronizer flops=0.
REQ-034 SHALL discard FIFO contents when reset asserts mid-operation; the first post-reset tick SHALL produce no pop.

Configuration
REQ-035 SHALL, with AUDIO_VOLUME_EN defined, arithmetic-right-shift both samples by volume at pop time (0=unity, sign preserved).
REQ-036 SHALL, without AUDIO_VOLUME_EN, omit the volume port and pass samples unscaled.

Structure
REQ-037 SHALL define SAMPLE_W=16, FRAME_W=64, the state enum and the stereo-pair struct in shared package audio_pkg.
REQ-038 SHALL implement storage in sub-module audio_sync_fifo (push/pop/level, no FSM logic).

Verification
REQ-039 SHALL cover reset mid-RUN with 5 pairs queued -> AUDIO_Reg=0, fifo_level=0, s_ready=0 while held, underrun_cnt=0.
REQ-040 SHALL cover priming: AUDIO_EN=1, push 8 pairs with first pair L=0x1234, R=0xABCD -> state RUN; next LRCLK fall -> AUDIO_Reg=0x1234_0000_ABCD_0000 at edge 3, frame_strobe high for 1 cycle.
REQ-041 SHALL cover full: push 16 pairs with no LRCLK activity -> fifo_level=16, s_ready=0, 17th pair held; one tick -> s_ready=1.
REQ-042 SHALL cover underrun: RUN with fifo_level=1, two LRCLK falls -> second frame AUDIO_Reg=0, underrun_cnt=1, state PRIME.
REQ-043 SHALL cover volume (macro on): volume=1, L=0x8000, R=0x4000 -> AUDIO_Reg[63:48]=0xC000, [31:16]=0x2000.
REQ-044 SHALL cover disable: AUDIO_EN dropped with 6 pairs queued -> fifo_level=0 next cycle, ticks produce no frame_strobe.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio frame feeder: sample/frame widths, feeder states and the stereo pair.
// Frame packing puts each 16-bit sample at the top of a 32-bit MSB-first slot.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int FRAME_W  = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } feed_state_t;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] left;
      logic signed [SAMPLE_W-1:0] right;
   } pair_t;

   function automatic logic [FRAME_W-1:0] pack_frame(input pair_t p);
      return {p.left, {SAMPLE_W{1'b0}}, p.right, {SAMPLE_W{1'b0}}};
   endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Stereo-pair FIFO: push/pop/level only; push visible at pop_dat one cycle later, pop_dat is combinational.
// Caller must gate push_vld on level < DEPTH and pop_vld on level != 0; flush empties it in one cycle.
module audio_sync_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push_vld,
   input  pair_t                  push_dat,
   input  logic                   pop_vld,
   output pair_t                  pop_dat,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);

   pair_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_vld && !pop_vld)      level <= level + LVL_ONE;
         else if (!push_vld && pop_vld) level <= level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/audio_frame_feeder.sv
// Feeds stereo pairs into a 64-bit I2S frame register once per LRCLK fall (load on 3rd Clk edge); optional
// AUDIO_VOLUME_EN adds a volume shift. Upstream is held off via s_ready when disabled or the FIFO is full.
module audio_frame_feeder
   import audio_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int PRIME_LVL = DEPTH/2
)(
   input  logic                   Clk,
   input  logic                   RESET_N,
   input  logic                   AUDIO_EN,
   input  logic                   LRCLK,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [SAMPLE_W-1:0]    s_left,
   input  logic [SAMPLE_W-1:0]    s_right,
   output logic [FRAME_W-1:0]     AUDIO_Reg,
   output logic                   frame_strobe,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [15:0]            underrun_cnt
`ifdef AUDIO_VOLUME_EN
   ,
   input  logic [3:0]             volume
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LVL);

   logic        lr_s1, lr_s2, lr_d;
   logic        tick;
   logic        push, pop;
   pair_t       in_pair, head, scaled;
   feed_state_t state;

   always_ff @(posedge Clk or negedge RESET_N) begin
      if (!RESET_N) begin
         lr_s1 <= 1'b0;
         lr_s2 <= 1'b0;
         lr_d  <= 1'b0;
      end else begin
         lr_s1 <= LRCLK;
         lr_s2 <= lr_s1;
         lr_d  <= lr_s2;
      end
   end

   assign tick = lr_d & ~lr_s2;

   // RESET_N gates s_ready so nothing is accepted while the FIFO is held cleared.
   assign s_ready = RESET_N && AUDIO_EN && (fifo_level < DEPTH_L);
   assign push    = s_valid && s_ready;
   assign pop     = AUDIO_EN && (state == RUN) && tick && (fifo_level != '0);
   assign in_pair = {s_left, s_right};

   audio_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (Clk),
      .rst_n    (RESET_N),
      .flush    (!AUDIO_EN),
      .push_vld (push),
      .push_dat (in_pair),
      .pop_vld  (pop),
      .pop_dat  (head),
      .level    (fifo_level)
   );

   always_comb begin
      scaled = head;
`ifdef AUDIO_VOLUME_EN
      scaled.left  = $signed(head.left)  >>> volume;
      scaled.right = $signed(head.right) >>> volume;
`endif
   end

   always_ff @(posedge Clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         AUDIO_Reg    <= '0;
         frame_strobe <= 1'b0;
         underrun_cnt <= '0;
      end else if (!AUDIO_EN) begin
         state        <= IDLE;
         AUDIO_Reg    <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= 1'b0;
         case (state)
            IDLE: state <= PRIME;
            PRIME: begin
               if (tick) begin
                  AUDIO_Reg    <= '0;
                  frame_strobe <= 1'b1;
               end
               if (fifo_level >= PRIME_L) state <= RUN;
            end
            RUN: begin
               if (tick) begin
                  frame_strobe <= 1'b1;
                  if (fifo_level != '0) begin
                     AUDIO_Reg <= pack_frame(scaled);
                  end else begin
                     AUDIO_Reg <= '0;
                     if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
                     state <= PRIME;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
